// File: rtl/weight_sram_pkg.sv
// Shared types and helpers for the weight SRAM burst reader.
package weight_sram_pkg;

   // Burst engine states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } rd_state_t;

   // Internal fetch addresses are kept wide so base + len*LANES never wraps
   localparam int EXT_ADDR_W = 32;

   // Address width for a given word count (at least one bit)
   function automatic int addr_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // LSB position of a lane inside a packed beat
   function automatic int lane_lsb(input int lane, input int bw);
      return lane * bw;
   endfunction

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry synchronous FIFO holding read beats (data + last + perr).
// Exposes its occupancy so the fetch engine can run credit-based flow control.
module rd_skid_fifo #(
   parameter int DATA_W = 34
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   output logic [1:0]        o_count
);

   logic [DATA_W-1:0] r_entry [2];
   logic              r_wptr;
   logic              r_rptr;
   logic [1:0]        r_count;
   logic              w_push;
   logic              w_pop;

   assign w_pop  = i_pop && (r_count != 2'd0);
   assign w_push = i_push && ((r_count != 2'd2) || w_pop);

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_push) r_wptr <= ~r_wptr;
         if (w_pop)  r_rptr <= ~r_rptr;
         r_count <= r_count + 2'(w_push) - 2'(w_pop);
      end
   end

   // Entry storage; contents are only meaningful while counted as occupied
   always_ff @(posedge clk) begin
      if (w_push) r_entry[r_wptr] <= i_data;
   end

   assign o_data  = r_entry[r_rptr];
   assign o_valid = (r_count != 2'd0);
   assign o_count = r_count;

endmodule

// File: rtl/weight_sram_burst.sv
// Weight SRAM with a single-word loader write port and a burst-read engine
// that streams LANES words per beat under valid/ready backpressure.
// Optional feature macro: SRAM_PARITY_EN (per-word even parity, reported on rd_perr).
module weight_sram_burst
   import weight_sram_pkg::*;
#(
   parameter  int WORD_NUM  = 79400,
   parameter  int BIT_WIDTH = 8,
   parameter  int LANES     = 4,
   parameter  int LEN_W     = 12,
   localparam int ADDR_W    = addr_width(WORD_NUM)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       csb,
   input  logic                       wsb,
   input  logic [ADDR_W-1:0]          waddr,
   input  logic [BIT_WIDTH-1:0]       wdata,
   input  logic                       rd_start,
   input  logic [ADDR_W-1:0]          rd_base,
   input  logic [LEN_W-1:0]           rd_len,
   output logic                       rd_busy,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [LANES*BIT_WIDTH-1:0] rd_data,
   output logic                       rd_last,
   output logic                       rd_perr
);

   localparam int BEAT_W = LANES * BIT_WIDTH;
   localparam int FIFO_W = BEAT_W + 2;

   logic [BIT_WIDTH-1:0]  r_mem [WORD_NUM];
`ifdef SRAM_PARITY_EN
   logic                  r_par [WORD_NUM];
   logic                  r_par_p1 [LANES];
   logic                  r_ok_p1  [LANES];
`endif

   rd_state_t             r_state;
   rd_state_t             w_state_nxt;
   logic [EXT_ADDR_W-1:0] r_addr_p0;
   logic [LEN_W-1:0]      r_len;
   logic [LEN_W-1:0]      r_issue_cnt;
   logic                  w_issue;
   logic                  w_issue_last;
   logic                  w_accept;
   logic                  w_credit_ok;

   logic [EXT_ADDR_W-1:0] w_lane_addr [LANES];
   logic                  w_lane_ok   [LANES];
   logic [ADDR_W-1:0]     w_lane_idx  [LANES];

   logic [BEAT_W-1:0]     r_data_p1;
   logic                  r_last_p1;
   logic                  r_vld_p1;
   logic                  w_perr_p1;

   logic [FIFO_W-1:0]     w_fifo_in;
   logic [FIFO_W-1:0]     w_fifo_out;
   logic                  w_fifo_valid;
   logic [1:0]            w_fifo_count;
   logic                  w_pop;
   logic                  w_head_last;
   logic                  w_head_perr;
   logic [BEAT_W-1:0]     w_head_data;

   // Loader write port; out-of-range addresses are dropped
   always_ff @(posedge clk) begin
      if (!csb && !wsb && (32'(waddr) < 32'(WORD_NUM))) begin
         r_mem[waddr] <= wdata;
`ifdef SRAM_PARITY_EN
         r_par[waddr] <= ^wdata;
`endif
      end
   end

   // Backdoor preload of one word (and its parity) for simulation
   task automatic load_param(input int index, input logic [BIT_WIDTH-1:0] value);
      if (index >= 0 && index < WORD_NUM) begin
         r_mem[ADDR_W'(index)] <= value;
`ifdef SRAM_PARITY_EN
         r_par[ADDR_W'(index)] <= ^value;
`endif
      end
   endtask

`ifdef SRAM_PARITY_EN
   // Backdoor write of data only, leaving the stored parity stale
   task automatic poke_data(input int index, input logic [BIT_WIDTH-1:0] value);
      if (index >= 0 && index < WORD_NUM) r_mem[ADDR_W'(index)] <= value;
   endtask
`endif

   assign w_accept = (r_state == ST_IDLE) && rd_start && (rd_len != '0);
   assign w_pop    = w_fifo_valid && rd_ready;

   // Issue only when the FIFO can absorb every beat already in flight plus this one;
   // a concurrent pop frees a slot, which keeps one beat per cycle under full ready
   assign w_credit_ok = ({1'b0, w_fifo_count} + 3'(r_vld_p1)) < (3'd2 + 3'(w_pop));

   // Burst FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Burst FSM next state and fetch issue
   always_comb begin
      w_state_nxt  = r_state;
      w_issue      = 1'b0;
      w_issue_last = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (w_credit_ok) begin
               w_issue      = 1'b1;
               w_issue_last = (r_issue_cnt == (r_len - LEN_W'(1)));
               if (w_issue_last) w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_pop && w_head_last) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Burst parameters and beat/address counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr_p0   <= '0;
         r_len       <= '0;
         r_issue_cnt <= '0;
      end else if (w_accept) begin
         r_addr_p0   <= EXT_ADDR_W'(rd_base);
         r_len       <= rd_len;
         r_issue_cnt <= '0;
      end else if (w_issue) begin
         r_addr_p0   <= r_addr_p0 + EXT_ADDR_W'(LANES);
         r_issue_cnt <= r_issue_cnt + LEN_W'(1);
      end
   end

   // Per-lane word address and range qualification for the current fetch
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         w_lane_addr[k] = r_addr_p0 + EXT_ADDR_W'(k);
         w_lane_ok[k]   = (w_lane_addr[k] < EXT_ADDR_W'(WORD_NUM));
         w_lane_idx[k]  = w_lane_addr[k][ADDR_W-1:0];
      end
   end

   // ---- p0 -> p1: registered SRAM read of one beat, out-of-range lanes read zero ----
   always_ff @(posedge clk) begin
      if (w_issue) begin
         for (int k = 0; k < LANES; k++) begin
            if (w_lane_ok[k]) r_data_p1[lane_lsb(k, BIT_WIDTH) +: BIT_WIDTH] <= r_mem[w_lane_idx[k]];
            else              r_data_p1[lane_lsb(k, BIT_WIDTH) +: BIT_WIDTH] <= '0;
`ifdef SRAM_PARITY_EN
            r_par_p1[k] <= w_lane_ok[k] ? r_par[w_lane_idx[k]] : 1'b0;
            r_ok_p1[k]  <= w_lane_ok[k];
`endif
         end
         r_last_p1 <= w_issue_last;
      end
   end

   // Read-stage valid, cleared by reset so an aborted burst leaves nothing in flight
   always_ff @(posedge clk) begin
      if (rst) r_vld_p1 <= 1'b0;
      else     r_vld_p1 <= w_issue;
   end

`ifdef SRAM_PARITY_EN
   // Parity check of the beat leaving the read stage
   always_comb begin
      w_perr_p1 = 1'b0;
      for (int k = 0; k < LANES; k++) begin
         if (r_ok_p1[k] && ((^r_data_p1[lane_lsb(k, BIT_WIDTH) +: BIT_WIDTH]) != r_par_p1[k]))
            w_perr_p1 = 1'b1;
      end
   end
`else
   assign w_perr_p1 = 1'b0;
`endif

   // ---- p1 -> output FIFO ----
   assign w_fifo_in = {r_last_p1, w_perr_p1, r_data_p1};

   rd_skid_fifo #(
      .DATA_W (FIFO_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_vld_p1),
      .i_data  (w_fifo_in),
      .i_pop   (w_pop),
      .o_data  (w_fifo_out),
      .o_valid (w_fifo_valid),
      .o_count (w_fifo_count)
   );

   assign w_head_last = w_fifo_out[FIFO_W-1];
   assign w_head_perr = w_fifo_out[FIFO_W-2];
   assign w_head_data = w_fifo_out[BEAT_W-1:0];

   assign rd_busy  = (r_state != ST_IDLE);
   assign rd_valid = w_fifo_valid;
   assign rd_data  = w_fifo_valid ? w_head_data : '0;
   assign rd_last  = w_fifo_valid && w_head_last;
   assign rd_perr  = w_fifo_valid && w_head_perr;

endmodule

// File: tb/tb_weight_sram_burst.sv
// Testbench for weight_sram_burst.
module tb_weight_sram_burst;

   localparam int WORD_NUM  = 79400;
   localparam int BIT_WIDTH = 8;
   localparam int LANES     = 4;
   localparam int LEN_W     = 12;
   localparam int ADDR_W    = 17;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 csb;
   logic                 wsb;
   logic [ADDR_W-1:0]    waddr;
   logic [BIT_WIDTH-1:0] wdata;
   logic                 rd_start;
   logic [ADDR_W-1:0]    rd_base;
   logic [LEN_W-1:0]     rd_len;
   logic                 rd_busy;
   logic                 rd_valid;
   logic                 rd_ready;
   logic [31:0]          rd_data;
   logic                 rd_last;
   logic                 rd_perr;

   int checks   = 0;
   int failures = 0;

   logic [31:0] cap_d [16];
   logic        cap_l [16];
   logic        cap_p [16];
   int          cap_n;

   always #5 clk = ~clk;

   weight_sram_burst #(
      .WORD_NUM  (WORD_NUM),
      .BIT_WIDTH (BIT_WIDTH),
      .LANES     (LANES),
      .LEN_W     (LEN_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .csb      (csb),
      .wsb      (wsb),
      .waddr    (waddr),
      .wdata    (wdata),
      .rd_start (rd_start),
      .rd_base  (rd_base),
      .rd_len   (rd_len),
      .rd_busy  (rd_busy),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .rd_data  (rd_data),
      .rd_last  (rd_last),
      .rd_perr  (rd_perr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [7:0] d);
      csb   = 1'b0;
      wsb   = 1'b0;
      waddr = ADDR_W'(a);
      wdata = d;
      tick();
      csb   = 1'b1;
      wsb   = 1'b1;
   endtask

   task automatic start(input int base, input int len);
      rd_start = 1'b1;
      rd_base  = ADDR_W'(base);
      rd_len   = LEN_W'(len);
      tick();
      rd_start = 1'b0;
   endtask

   // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating
   task automatic collect(input int n, input int mode, input bit end_chk);
      bit          pv  = 1'b0;
      bit          pr  = 1'b0;
      logic [31:0] pd  = '0;
      int          cyc = 0;
      cap_n = 0;
      while (cap_n < n && cyc < 200) begin
         rd_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         if (pv && !pr) begin
            chk1("hold_valid", rd_valid, 1'b1);
            chk("hold_data", rd_data, pd);
         end
         if (rd_valid && rd_ready) begin
            cap_d[cap_n] = rd_data;
            cap_l[cap_n] = rd_last;
            cap_p[cap_n] = rd_perr;
            cap_n++;
         end
         pv = rd_valid;
         pr = rd_ready;
         pd = rd_data;
         tick();
         cyc++;
      end
      rd_ready = 1'b1;
      chk("beat_count", 32'(cap_n), 32'(n));
      if (end_chk) begin
         chk1("busy_after_last", rd_busy, 1'b0);
         chk1("valid_after_last", rd_valid, 1'b0);
      end
   endtask

   task automatic chk_beat(input string tag, input int i, input logic [31:0] d, input logic l);
      chk({tag, "_data"}, cap_d[i], d);
      chk1({tag, "_last"}, cap_l[i], l);
      chk1({tag, "_perr"}, cap_p[i], 1'b0);
   endtask

   initial begin
      rst      = 1'b1;
      csb      = 1'b1;
      wsb      = 1'b1;
      waddr    = '0;
      wdata    = '0;
      rd_start = 1'b0;
      rd_base  = '0;
      rd_len   = '0;
      rd_ready = 1'b0;
      tick();
      tick();
      tick();
      chk1("rst_busy", rd_busy, 1'b0);
      chk1("rst_valid", rd_valid, 1'b0);
      chk1("rst_last", rd_last, 1'b0);
      chk1("rst_perr", rd_perr, 1'b0);
      chk("rst_data", rd_data, 32'h0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 64; i++) wr(i, 8'(i));
      wr(WORD_NUM - 2, 8'h5A);
      wr(WORD_NUM - 1, 8'hA5);

      // 1: base 0, len 4, ready high
      rd_ready = 1'b1;
      start(0, 4);
      chk1("t1_busy", rd_busy, 1'b1);
      chk1("t1_lat0", rd_valid, 1'b0);
      tick();
      chk1("t1_lat1", rd_valid, 1'b0);
      tick();
      chk1("t1_lat2", rd_valid, 1'b1);
      collect(4, 0, 1'b1);
      chk_beat("t1_b0", 0, 32'h03020100, 1'b0);
      chk_beat("t1_b1", 1, 32'h07060504, 1'b0);
      chk_beat("t1_b2", 2, 32'h0B0A0908, 1'b0);
      chk_beat("t1_b3", 3, 32'h0F0E0D0C, 1'b1);

      // 2: base 10, len 3, ready toggling
      start(10, 3);
      collect(3, 1, 1'b1);
      chk_beat("t2_b0", 0, 32'h0D0C0B0A, 1'b0);
      chk_beat("t2_b1", 1, 32'h11100F0E, 1'b0);
      chk_beat("t2_b2", 2, 32'h15141312, 1'b1);

      // 3: burst straddling the top of memory
      start(WORD_NUM - 2, 1);
      collect(1, 0, 1'b1);
      chk_beat("t3_b0", 0, 32'h0000A55A, 1'b1);

      // 4: write mem[12] in the same cycle its beat is fetched
      start(8, 2);
      tick();
      csb   = 1'b0;
      wsb   = 1'b0;
      waddr = ADDR_W'(12);
      wdata = 8'hAA;
      tick();
      csb   = 1'b1;
      wsb   = 1'b1;
      collect(2, 0, 1'b1);
      chk_beat("t4_b0", 0, 32'h0B0A0908, 1'b0);
      chk_beat("t4_b1", 1, 32'h0F0E0D0C, 1'b1);
      start(12, 1);
      collect(1, 0, 1'b1);
      chk_beat("t4_new", 0, 32'h0F0E0DAA, 1'b1);

      // 5: reset in the middle of a len 8 burst, then a zero-length start
      start(0, 8);
      collect(2, 0, 1'b0);
      chk_beat("t5_b0", 0, 32'h03020100, 1'b0);
      chk_beat("t5_b1", 1, 32'h07060504, 1'b0);
      rst = 1'b1;
      tick();
      chk1("t5_rst_valid", rd_valid, 1'b0);
      chk1("t5_rst_busy", rd_busy, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk1("t5_no_beats", rd_valid, 1'b0);
      end
      start(0, 0);
      chk1("t5_len0_busy", rd_busy, 1'b0);
      tick();
      chk1("t5_len0_valid", rd_valid, 1'b0);
      chk1("t5_len0_busy2", rd_busy, 1'b0);
      start(60, 1);
      collect(1, 0, 1'b1);
      chk_beat("t5_mem_kept", 0, 32'h3F3E3D3C, 1'b1);

`ifdef SRAM_PARITY_EN
      // 6: stale parity on mem[5]
      dut.poke_data(5, 8'h04);
      tick();
      start(4, 1);
      collect(1, 0, 1'b1);
      chk("t6_data", cap_d[0], 32'h07060404);
      chk1("t6_perr", cap_p[0], 1'b1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
